// File: rtl/qenc_counter.sv
// Quadrature encoder decode core: synchronises and glitch-filters A/B/Z, 4x-decodes into a
// wrapping position counter and measures signed velocity over a programmable window.
module qenc_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int VEL_WIDTH = 16,
    parameter int FILT_LEN  = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        enc_a,
    input  logic                        enc_b,
    input  logic                        enc_z,
    input  logic                        ctrl_enable,
    input  logic                        ctrl_clear,
    input  logic                        ctrl_z_reset_en,
    input  logic                        preset_load,
    input  logic [CNT_WIDTH-1:0]        preset_value,
    input  logic [31:0]                 sample_period,
    output logic [CNT_WIDTH-1:0]        position,
    output logic signed [VEL_WIDTH-1:0] velocity,
    output logic                        vel_valid,
    output logic                        direction,
    output logic [7:0]                  err_count
);

    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILT_LEN - 1);
    localparam logic signed [VEL_WIDTH:0] L_MAX = {2'b00, {(VEL_WIDTH-1){1'b1}}};
    localparam logic signed [VEL_WIDTH:0] L_MIN = -L_MAX;

    logic [2:0] w_raw;
    logic [2:0] w_filt;

    assign w_raw = {enc_z, enc_b, enc_a};

    // Per pin: 2-flop synchroniser followed by a stability filter.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pin
            logic [1:0]     r_sync;
            logic           r_filt;
            logic [FCW-1:0] r_cnt;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    r_sync <= 2'b00;
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    if (r_sync[1] == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == FILT_MAX) begin
                        r_filt <= r_sync[1];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic [1:0] r_prev_ab;
    logic       r_prev_z;
    logic [1:0] w_cur_ph;
    logic [1:0] w_prev_ph;
    logic [1:0] w_diff;
    logic       w_fwd;
    logic       w_rev;
    logic       w_illegal;
    logic       w_step_en;
    logic       w_z_rise;
    logic signed [1:0] w_step;

    // Map {A,B} onto a phase index 0..3 so the forward order is simply +1 mod 4.
    assign w_cur_ph  = {w_filt[0], w_filt[0] ^ w_filt[1]};
    assign w_prev_ph = {r_prev_ab[1], r_prev_ab[1] ^ r_prev_ab[0]};
    assign w_diff    = w_cur_ph - w_prev_ph;
    assign w_fwd     = (w_diff == 2'd1);
    assign w_rev     = (w_diff == 2'd3);
    assign w_illegal = (w_diff == 2'd2);
    assign w_step_en = ctrl_enable & (w_fwd | w_rev);
    assign w_step    = !w_step_en ? 2'sd0 : (w_fwd ? 2'sd1 : -2'sd1);
    assign w_z_rise  = w_filt[2] & ~r_prev_z;

    logic [CNT_WIDTH-1:0] r_pos;
    logic                 r_dir;
    logic [7:0]           r_err;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_prev_ab <= 2'b00;
            r_prev_z  <= 1'b0;
            r_pos     <= '0;
            r_dir     <= 1'b1;
            r_err     <= 8'd0;
        end else begin
            r_prev_ab <= {w_filt[0], w_filt[1]};
            r_prev_z  <= w_filt[2];

            if (ctrl_clear) begin
                r_pos <= '0;
            end else if (preset_load) begin
                r_pos <= preset_value;
            end else if (ctrl_z_reset_en && w_z_rise) begin
                r_pos <= '0;
            end else if (w_step_en) begin
                r_pos <= w_fwd ? r_pos + CNT_WIDTH'(1) : r_pos - CNT_WIDTH'(1);
            end

            if (w_step_en) begin
                r_dir <= w_fwd;
            end

            if (ctrl_clear) begin
                r_err <= 8'd0;
            end else if (w_illegal && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    logic [31:0]                 r_win_cnt;
    logic signed [VEL_WIDTH-1:0] r_acc;
    logic signed [VEL_WIDTH-1:0] r_vel;
    logic                        r_vel_valid;
    logic signed [VEL_WIDTH:0]   w_sum;
    logic signed [VEL_WIDTH-1:0] w_sat;
    logic                        w_win_on;
    logic                        w_win_end;

    assign w_sum = $signed({r_acc[VEL_WIDTH-1], r_acc})
                 + $signed({{(VEL_WIDTH-1){w_step[1]}}, w_step});

    always_comb begin
        w_sat = w_sum[VEL_WIDTH-1:0];
        if (w_sum > L_MAX) begin
            w_sat = L_MAX[VEL_WIDTH-1:0];
        end else if (w_sum < L_MIN) begin
            w_sat = L_MIN[VEL_WIDTH-1:0];
        end
    end

    // '>=' rather than '==' so shrinking sample_period mid-window expires it promptly.
    assign w_win_on  = ctrl_enable && (sample_period != 32'd0);
    assign w_win_end = w_win_on && (r_win_cnt >= sample_period - 32'd1);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_win_cnt   <= 32'd0;
            r_acc       <= '0;
            r_vel       <= '0;
            r_vel_valid <= 1'b0;
        end else begin
            r_vel_valid <= 1'b0;
            if (ctrl_clear) begin
                r_win_cnt <= 32'd0;
                r_acc     <= '0;
                r_vel     <= '0;
            end else if (w_win_end) begin
                r_vel       <= w_sat;
                r_vel_valid <= 1'b1;
                r_win_cnt   <= 32'd0;
                r_acc       <= '0;
            end else if (w_win_on) begin
                r_win_cnt <= r_win_cnt + 32'd1;
                r_acc     <= w_sat;
            end
        end
    end

    assign position  = r_pos;
    assign velocity  = r_vel;
    assign vel_valid = r_vel_valid;
    assign direction = r_dir;
    assign err_count = r_err;

endmodule

// File: doc/qenc_counter.md
# qenc_counter

Quadrature-encoder decode core for the encoder IP. It synchronises and glitch-filters the A/B/Z pins, performs 4x quadrature decoding into a wrapping position counter, and measures velocity over a programmable sample window. It sits directly behind the AXI4-Lite slave register file: the register file drives its control inputs and reads back its status outputs.

## Interface
- CNT_WIDTH, 32: position counter width; position wraps modulo 2^CNT_WIDTH.
- VEL_WIDTH, 16: signed velocity accumulator/output width; must be ≥ 2.
- FILT_LEN, 4: number of consecutive stable cycles needed to accept a pin change; must be ≥ 1.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  reset; asynchronous, active-low; one clock, no other reset.
- enc_a, enc_b, enc_z  in  1 each  raw asynchronous encoder pins.
- ctrl_enable  in  1  enables counting and the velocity window.
- ctrl_clear  in  1  single-cycle pulse: clear position, velocity, accumulator, window counter and err_count.
- ctrl_z_reset_en  in  1  when high, a rising edge on the filtered Z clears position.
- preset_load  in  1  single-cycle pulse: position <= preset_value.
- preset_value  in  CNT_WIDTH  preset value.
- sample_period  in  32  velocity window length in cycles; 0 disables the window.
- position  out  CNT_WIDTH  current count.
- velocity  out  VEL_WIDTH  signed step count from the last completed window.
- vel_valid  out  1  one-cycle pulse when velocity updates.
- direction  out  1  direction of the last accepted step: 1 = forward, 0 = reverse.
- err_count  out  8  saturating count of illegal transitions.

## Operation
- Sync: each pin passes through a 2-flop synchroniser.
- Filter, per pin (filtered bit f, counter c): if the synced bit equals f, c <= 0. Otherwise, if c == FILT_LEN-1, f <= synced bit and c <= 0; else c <= c+1.
- Decode: compare filtered {A,B} with its value on the previous cycle. The forward sequence is 00→01→11→10→00, and each forward transition gives +1. The reverse sequence gives −1. No change gives 0.
- Illegal transition (both bits change in one cycle): no step; err_count increments and saturates at 255. err_count increments even when ctrl_enable is low.
- Position priority, highest first: ctrl_clear, preset_load, Z reset, step. Only the highest-priority action takes effect in a cycle. For example, a step coinciding with preset_load is dropped.
- Z reset: requires ctrl_z_reset_en. Fires on a filtered Z 0→1 transition and sets position to 0.
- ctrl_enable low:
  - Synchronisers, filters and the previous-state register keep running, so steps taken while disabled are discarded with no burst on re-enable.
  - Position steps, the window counter and the accumulator freeze.
  - clear, preset and Z reset still act.
- Velocity:
  - The window counter counts enabled cycles.
  - The signed accumulator adds every step and saturates at ±(2^(VEL_WIDTH−1)−1).
  - When the window counter reaches sample_period−1: velocity <= accumulator plus this cycle's step, vel_valid = 1, and the accumulator and window counter restart at 0.
  - sample_period == 0: window idle, velocity holds, vel_valid stays 0.
  - Changing sample_period mid-window takes effect at the next comparison. If the counter is already ≥ the new value, the window expires on the next cycle.
- direction updates only on accepted steps. It is unchanged by clear and preset.

## Timing
- Reset values: position 0, velocity 0, vel_valid 0, direction 1, err_count 0. Internal state: synchronisers 0, filters 0, c 0, window counter 0, accumulator 0.
- Reset mid-operation drops all state immediately. After release, pins at a static nonzero level are filtered in like a normal change.
- Latency: a pin change captured at edge 0 reaches the filter register at edge FILT_LEN+1 and appears on position after edge FILT_LEN+2. With the default FILT_LEN = 4, that is edge 6.
- Glitches shorter than FILT_LEN synced cycles are rejected.
- ctrl_clear and preset_load take effect on position at the next edge (1-cycle latency).
- vel_valid is high exactly one cycle per window. Windows are sample_period enabled cycles long.

## Test plan
- Reset: assert ARESETN low mid-count at an arbitrary (non-edge) time → all outputs return to their reset values immediately; after release, position is 0.
- Forward/reverse counting: drive 10 full forward cycles, one state change every 20 cycles → position 40, direction 1. Then drive one reverse step from 0 → position 0xFFFFFFFF, direction 0.
- Filtering and illegal transitions:
  - A pulse on enc_a lasting FILT_LEN−1 cycles → no step.
  - Holding {A,B} at 00, jump to 11 → err_count 1, position unchanged.
- Index: ctrl_z_reset_en = 1, position 123, Z pulse of 10 cycles → position 0. The same with ctrl_z_reset_en = 0 → position stays 123.
- Velocity: sample_period 1000, one forward step every 50 cycles → each vel_valid pulse shows velocity 20. Set sample_period = 0 → vel_valid stops and velocity holds 20.
- Priority: preset_value 0x55, assert ctrl_clear and preset_load in the same cycle as a step → position 0. Then preset_load alone → position 0x55.
